// File: rtl/pc_gen.sv
// Fetch-address generator for the IF stage: sequential stepping, flush and
// branch redirects, a pending target held across stalls, and a misalignment flag.
module pc_gen #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int unsigned       STEP       = 4,
  parameter int unsigned       ALIGN_BITS = 2,
  parameter int unsigned       STALL_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  flush_target_i,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               redirect_pending_o,
  output logic               misalign_o
);

  // With ALIGN_BITS=0 the mask is zero, so alignment is a no-op and the flag never fires.
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              ce_q, ce_d;
  logic              pending_q, pending_d;
  logic              misalign_q, misalign_d;

  // Only stall[0] holds the pc; the upper bits belong to later stages.
  logic unused_stall;
  assign unused_stall = ^stall;

  function automatic logic [ADDR_W-1:0] aligned(input logic [ADDR_W-1:0] t);
    return t & ~LOW_MASK;
  endfunction

  function automatic logic low_bits_set(input logic [ADDR_W-1:0] t);
    return |(t & LOW_MASK);
  endfunction

  always_comb begin
    pc_d        = pc_q;
    ce_d        = 1'b1;
    pending_d   = pending_q;
    pend_addr_d = pend_addr_q;
    misalign_d  = 1'b0;
    if (!ce_q) begin
      pc_d = RESET_VEC;
    end else if (flush_i) begin
      pc_d       = aligned(flush_target_i);
      pending_d  = 1'b0;
      misalign_d = low_bits_set(flush_target_i);
    end else if (!stall[0]) begin
      pending_d = 1'b0;
      if (branch_flag_i) begin
        pc_d       = aligned(branch_target_address_i);
        misalign_d = low_bits_set(branch_target_address_i);
      end else if (pending_q) begin
        pc_d = pend_addr_q;
      end else begin
        pc_d = pc_q + ADDR_W'(STEP);
      end
    end else if (branch_flag_i) begin
      // Stalled branch: remember it; a newer one replaces the older target.
      pending_d   = 1'b1;
      pend_addr_d = aligned(branch_target_address_i);
      misalign_d  = low_bits_set(branch_target_address_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_VEC;
      ce_q        <= 1'b0;
      pending_q   <= 1'b0;
      pend_addr_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ce_q        <= ce_d;
      pending_q   <= pending_d;
      pend_addr_q <= pend_addr_d;
      misalign_q  <= misalign_d;
    end
  end

  assign pc                 = pc_q;
  assign ce                 = ce_q;
  assign redirect_pending_o = pending_q;
  assign misalign_o         = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Randomised and directed check of pc_gen (default and 16-bit wrap configurations)
// against a rule-level reference model.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  stall_v [2];
  logic        flush_v [2];
  logic [31:0] ftgt_v  [2];
  logic        br_v    [2];
  logic [31:0] btgt_v  [2];

  logic [31:0] pc0;
  logic [15:0] pc1;
  logic        ce_o [2];
  logic        pend_o [2];
  logic        mis_o [2];
  logic [31:0] pc_o [2];
  assign pc_o[0] = pc0;
  assign pc_o[1] = {16'h0, pc1};

  pc_gen u_dut0 (
    .clk(clk), .rst(rst), .stall(stall_v[0]), .flush_i(flush_v[0]),
    .flush_target_i(ftgt_v[0]), .branch_flag_i(br_v[0]),
    .branch_target_address_i(btgt_v[0]), .pc(pc0), .ce(ce_o[0]),
    .redirect_pending_o(pend_o[0]), .misalign_o(mis_o[0])
  );

  pc_gen #(.ADDR_W(16), .RESET_VEC(16'hFFFC), .STEP(2), .ALIGN_BITS(1), .STALL_W(6)) u_dut1 (
    .clk(clk), .rst(rst), .stall(stall_v[1]), .flush_i(flush_v[1]),
    .flush_target_i(ftgt_v[1][15:0]), .branch_flag_i(br_v[1]),
    .branch_target_address_i(btgt_v[1][15:0]), .pc(pc1), .ce(ce_o[1]),
    .redirect_pending_o(pend_o[1]), .misalign_o(mis_o[1])
  );

  // Reference model state, plain integers
  longint m_pc [2];
  longint m_paddr [2];
  bit     m_ce [2];
  bit     m_pend [2];
  bit     m_mis [2];

  int n_checks = 0;
  int n_errors = 0;

  function automatic int aw(int i);     return (i == 0) ? 32 : 16; endfunction
  function automatic longint stp(int i); return (i == 0) ? 4 : 2; endfunction
  function automatic longint lo(int i);  return (i == 0) ? 4 : 2; endfunction
  function automatic longint rv(int i);  return (i == 0) ? 0 : 'hFFFC; endfunction
  function automatic longint modv(int i); return longint'(1) << aw(i); endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_pc[i] = rv(i); m_ce[i] = 0; m_pend[i] = 0; m_paddr[i] = 0; m_mis[i] = 0;
  endtask

  task automatic model_edge(input int i);
    longint t;
    if (!rst) begin
      model_reset(i);
    end else if (!m_ce[i]) begin
      m_ce[i] = 1; m_pc[i] = rv(i); m_mis[i] = 0;
    end else begin
      m_mis[i] = 0;
      if (flush_v[i]) begin
        t = longint'(ftgt_v[i]) % modv(i);
        m_pc[i] = t - (t % lo(i)); m_pend[i] = 0; m_mis[i] = (t % lo(i)) != 0;
      end else if (!stall_v[i][0]) begin
        if (br_v[i]) begin
          t = longint'(btgt_v[i]) % modv(i);
          m_pc[i] = t - (t % lo(i)); m_mis[i] = (t % lo(i)) != 0;
        end else if (m_pend[i]) begin
          m_pc[i] = m_paddr[i];
        end else begin
          m_pc[i] = (m_pc[i] + stp(i)) % modv(i);
        end
        m_pend[i] = 0;
      end else if (br_v[i]) begin
        t = longint'(btgt_v[i]) % modv(i);
        m_pend[i] = 1; m_paddr[i] = t - (t % lo(i)); m_mis[i] = (t % lo(i)) != 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("pc[%0d]", i), pc_o[i], m_pc[i]);
      check($sformatf("ce[%0d]", i), ce_o[i], m_ce[i]);
      check($sformatf("pend[%0d]", i), pend_o[i], m_pend[i]);
      check($sformatf("mis[%0d]", i), mis_o[i], m_mis[i]);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      stall_v[i] = '0; flush_v[i] = 0; ftgt_v[i] = '0; br_v[i] = 0; btgt_v[i] = '0;
    end
  endtask

  initial begin
    longint exp0 [4];
    longint exp1 [4];
    exp0 = '{'h0, 'h4, 'h8, 'hC};
    exp1 = '{'hFFFC, 'hFFFE, 'h0, 'h2};
    idle_inputs();
    model_reset(0);
    model_reset(1);

    // 1: reset then sequential stepping (and 16-bit wrap on the second instance)
    for (int k = 0; k < 3; k++) step_cycle();
    check("t1_rst_ce", ce_o[0], 0);
    check("t1_rst_pc", pc_o[0], 0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step_cycle();
      check($sformatf("t1_seq%0d", k), pc_o[0], exp0[k]);
      check($sformatf("t6_wrap%0d", k), pc_o[1], exp1[k]);
      check($sformatf("t1_ce%0d", k), ce_o[0], 1);
    end

    // 2: asynchronous reset between edges
    for (int k = 0; k < 40 && m_pc[0] != 'h40; k++) step_cycle();
    check("t2_reach40", pc_o[0], 'h40);
    #2 rst = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check("t2_async_pc", pc_o[0], 0);
    check("t2_async_ce", ce_o[0], 0);
    check("t2_async_pc1", pc_o[1], 'hFFFC);
    @(negedge clk);
    step_cycle();
    rst = 1'b1;

    // 3: branch arriving during a stall
    for (int k = 0; k < 40 && m_pc[0] != 'h10; k++) step_cycle();
    check("t3_reach10", pc_o[0], 'h10);
    stall_v[0] = 6'b000001; br_v[0] = 1; btgt_v[0] = 32'h203;
    step_cycle();
    check("t3_hold", pc_o[0], 'h10);
    check("t3_pend", pend_o[0], 1);
    check("t3_mis", mis_o[0], 1);
    br_v[0] = 0; btgt_v[0] = '0;
    step_cycle();
    check("t3_mis_once", mis_o[0], 0);
    step_cycle();
    stall_v[0] = '0;
    step_cycle();
    check("t3_apply", pc_o[0], 'h200);
    check("t3_pend_clr", pend_o[0], 0);
    step_cycle();
    check("t3_next", pc_o[0], 'h204);

    // 4: flush beats stall, branch and pending
    stall_v[0] = 6'b000001; br_v[0] = 1; btgt_v[0] = 32'h300;
    step_cycle();
    check("t4_pend", pend_o[0], 1);
    flush_v[0] = 1; ftgt_v[0] = 32'h80; btgt_v[0] = 32'h500;
    step_cycle();
    check("t4_flush_pc", pc_o[0], 'h80);
    check("t4_flush_pend", pend_o[0], 0);
    idle_inputs();
    step_cycle();
    check("t4_after", pc_o[0], 'h84);

    // 5: fresh branch at stall release beats the pending target; also 16-bit misaligned branch
    stall_v[0] = 6'b000001; br_v[0] = 1; btgt_v[0] = 32'h300;
    step_cycle();
    stall_v[0] = '0; btgt_v[0] = 32'h600;
    br_v[1] = 1; btgt_v[1] = 32'h11;
    step_cycle();
    check("t5_fresh_pc", pc_o[0], 'h600);
    check("t5_fresh_pend", pend_o[0], 0);
    check("t6_br_pc", pc_o[1], 'h10);
    check("t6_br_mis", mis_o[1], 1);
    idle_inputs();
    step_cycle();
    check("t5_next", pc_o[0], 'h604);

    // Random phase: both instances, independent stimulus
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++) begin
        stall_v[i] = 6'($urandom);
        stall_v[i][0] = ($urandom_range(0, 99) < 35);
        flush_v[i] = ($urandom_range(0, 99) < 7);
        br_v[i] = ($urandom_range(0, 99) < 25);
        ftgt_v[i] = $urandom;
        btgt_v[i] = $urandom;
      end
      step_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
